// File: rtl/ps2_scancode_receiver_if.sv
// PS/2 keyboard pin pair plus decoded scan-code outputs.
// The keyboard side (master) drives the pins; the receiver (slave) drives the results.
interface ps2_scancode_receiver_if;
    logic       clk_kb;
    logic       data_kb;
    logic [7:0] oScanCode;
    logic       oCodeValid;
    logic       oBreak;
    logic       oExtended;
    logic       oFrameError;
    logic       oBusy;

    modport master (
        output clk_kb, data_kb,
        input  oScanCode, oCodeValid, oBreak, oExtended, oFrameError, oBusy
    );

    modport slave (
        input  clk_kb, data_kb,
        output oScanCode, oCodeValid, oBreak, oExtended, oFrameError, oBusy
    );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronizes and deglitches the pins, decodes 11-bit frames,
// and folds E0/F0 prefixes into flags on the following scan code.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a PS/2 clock fall)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, then publishing the byte
module ps2_scancode_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                    Clock,
    input  logic                    Reset,
    ps2_scancode_receiver_if.slave  ps2
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clkSync;
    logic [1:0]    dataSync;
    logic          clkFilt;
    logic [FW-1:0] filtCnt;
    logic          fall;

    state_t        state;
    logic [7:0]    shReg;
    logic          parityBit;
    logic [2:0]    bitCnt;
    logic [TW-1:0] timeoutCnt;
    logic          breakPend;
    logic          extPend;
    logic          dataBit;

    assign dataBit   = dataSync[1];
    assign ps2.oBusy = (state != IDLE);

    // The filtered clock only follows the synced pin after it has disagreed
    // for FILTER_LEN consecutive cycles.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkFilt  <= 1'b1;
            filtCnt  <= '0;
            fall     <= 1'b0;
        end else begin
            clkSync  <= {clkSync[0], ps2.clk_kb};
            dataSync <= {dataSync[0], ps2.data_kb};
            fall     <= 1'b0;
            if (clkSync[1] != clkFilt) begin
                if (filtCnt == FILT_LAST) begin
                    clkFilt <= clkSync[1];
                    filtCnt <= '0;
                    fall    <= clkFilt;
                end else begin
                    filtCnt <= filtCnt + 1'b1;
                end
            end else begin
                filtCnt <= '0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state           <= IDLE;
            shReg           <= '0;
            parityBit       <= 1'b0;
            bitCnt          <= '0;
            timeoutCnt      <= TO_RELOAD;
            breakPend       <= 1'b0;
            extPend         <= 1'b0;
            ps2.oScanCode   <= '0;
            ps2.oCodeValid  <= 1'b0;
            ps2.oBreak      <= 1'b0;
            ps2.oExtended   <= 1'b0;
            ps2.oFrameError <= 1'b0;
        end else begin
            ps2.oCodeValid  <= 1'b0;
            ps2.oFrameError <= 1'b0;
            if (fall) begin
                timeoutCnt <= TO_RELOAD;
                case (state)
                    IDLE: begin
                        if (!dataBit) begin
                            state  <= DATA;
                            bitCnt <= '0;
                        end
                    end
                    DATA: begin
                        shReg  <= {dataBit, shReg[7:1]};
                        bitCnt <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parityBit <= dataBit;
                        state     <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (dataBit && (^{shReg, parityBit})) begin
                            if (shReg == 8'hF0) begin
                                breakPend <= 1'b1;
                            end else if (shReg == 8'hE0) begin
                                extPend <= 1'b1;
                            end else begin
                                ps2.oScanCode  <= shReg;
                                ps2.oBreak     <= breakPend;
                                ps2.oExtended  <= extPend;
                                ps2.oCodeValid <= 1'b1;
                                breakPend      <= 1'b0;
                                extPend        <= 1'b0;
                            end
                        end else begin
                            ps2.oFrameError <= 1'b1;
                            breakPend       <= 1'b0;
                            extPend         <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                timeoutCnt <= TO_RELOAD;
            end else if (timeoutCnt == '0) begin
                // Keyboard stalled mid-frame: drop the partial byte and any prefix.
                state           <= IDLE;
                ps2.oFrameError <= 1'b1;
                breakPend       <= 1'b0;
                extPend         <= 1'b0;
                timeoutCnt      <= TO_RELOAD;
            end else begin
                timeoutCnt <= timeoutCnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: bit-bangs PS/2 frames on the pins and
// checks decoded codes, prefix flags, error strobes, timeout, glitch and reset behaviour.
module tb_ps2_scancode_receiver;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    ps2_scancode_receiver_if ifc ();

    ps2_scancode_receiver #(.FILTER_LEN(2), .TIMEOUT_CYCLES(200)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .ps2   (ifc.slave)
    );

    int nAssert = 0;
    int nFail = 0;
    int validCnt = 0;
    int errCnt = 0;
    int v0 = 0;
    int e0 = 0;

    // Strobe counters, sampled away from the active edge.
    always @(negedge Clock) begin
        if (ifc.oCodeValid === 1'b1) validCnt = validCnt + 1;
        if (ifc.oFrameError === 1'b1) errCnt = errCnt + 1;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic parFlip, input logic stopBit);
        return {stopBit, (~^d) ^ parFlip, d, 1'b0};
    endfunction

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ifc.data_kb = bits[i];
            waitCycles(20);
            ifc.clk_kb = 1'b0;
            waitCycles(20);
            ifc.clk_kb = 1'b1;
        end
    endtask

    task automatic sendByte(input logic [7:0] d, input logic parFlip, input logic stopBit);
        sendBits(frame(d, parFlip, stopBit), 11);
        ifc.data_kb = 1'b1;
        waitCycles(10);
    endtask

    task automatic snap();
        v0 = validCnt;
        e0 = errCnt;
    endtask

    task automatic expectCode(input string tag, input logic [7:0] code, input logic brk,
                              input logic ext, input int nErr);
        check({tag, "_validCount"}, validCnt, v0 + 1);
        check({tag, "_errCount"}, errCnt, e0 + nErr);
        check({tag, "_scanCode"}, {24'd0, ifc.oScanCode}, {24'd0, code});
        check({tag, "_break"}, {31'd0, ifc.oBreak}, {31'd0, brk});
        check({tag, "_extended"}, {31'd0, ifc.oExtended}, {31'd0, ext});
    endtask

    task automatic expectNone(input string tag, input int nErr);
        check({tag, "_validCount"}, validCnt, v0);
        check({tag, "_errCount"}, errCnt, e0 + nErr);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_scanCode"}, {24'd0, ifc.oScanCode}, 32'd0);
        check({tag, "_valid"}, {31'd0, ifc.oCodeValid}, 32'd0);
        check({tag, "_break"}, {31'd0, ifc.oBreak}, 32'd0);
        check({tag, "_extended"}, {31'd0, ifc.oExtended}, 32'd0);
        check({tag, "_frameError"}, {31'd0, ifc.oFrameError}, 32'd0);
        check({tag, "_busy"}, {31'd0, ifc.oBusy}, 32'd0);
    endtask

    initial begin
        ifc.clk_kb  = 1'b1;
        ifc.data_kb = 1'b1;
        Reset = 1'b1;
        waitCycles(5);
        checkAllZero("reset");
        Reset = 1'b0;
        waitCycles(10);

        // Plain make code
        snap();
        sendByte(8'h1C, 1'b0, 1'b1);
        expectCode("plain1C", 8'h1C, 1'b0, 1'b0, 0);

        // Break prefix
        snap();
        sendByte(8'hF0, 1'b0, 1'b1);
        expectNone("prefixF0", 0);
        sendByte(8'h1C, 1'b0, 1'b1);
        expectCode("break1C", 8'h1C, 1'b1, 1'b0, 0);

        // Extended break, then flags must be gone on the next code
        snap();
        sendByte(8'hE0, 1'b0, 1'b1);
        sendByte(8'hF0, 1'b0, 1'b1);
        expectNone("prefixE0F0", 0);
        sendByte(8'h75, 1'b0, 1'b1);
        expectCode("extBreak75", 8'h75, 1'b1, 1'b1, 0);
        snap();
        sendByte(8'h1C, 1'b0, 1'b1);
        expectCode("flagsCleared", 8'h1C, 1'b0, 1'b0, 0);

        // Parity error and stop-bit error hold the previous code
        snap();
        sendByte(8'h2A, 1'b1, 1'b1);
        expectNone("parityErr", 1);
        check("parityErr_scanHeld", {24'd0, ifc.oScanCode}, 32'h1C);
        snap();
        sendByte(8'h33, 1'b0, 1'b0);
        expectNone("stopErr", 1);
        check("stopErr_scanHeld", {24'd0, ifc.oScanCode}, 32'h1C);

        // A bad frame discards a pending break prefix
        snap();
        sendByte(8'hF0, 1'b0, 1'b1);
        sendByte(8'h2A, 1'b1, 1'b1);
        sendByte(8'h1C, 1'b0, 1'b1);
        expectCode("errClearsPend", 8'h1C, 1'b0, 1'b0, 1);

        // Timeout after start + 4 data bits
        snap();
        sendBits(frame(8'h1C, 1'b0, 1'b1), 5);
        waitCycles(130);
        check("timeoutEarly_busy", {31'd0, ifc.oBusy}, 32'd1);
        check("timeoutEarly_err", errCnt, e0);
        waitCycles(100);
        check("timeout_err", errCnt, e0 + 1);
        check("timeout_busy", {31'd0, ifc.oBusy}, 32'd0);
        check("timeout_valid", validCnt, v0);
        snap();
        sendByte(8'h1C, 1'b0, 1'b1);
        expectCode("afterTimeout", 8'h1C, 1'b0, 1'b0, 0);

        // Single-cycle clock glitch with data low must not start a frame
        snap();
        ifc.data_kb = 1'b0;
        waitCycles(5);
        ifc.clk_kb = 1'b0;
        waitCycles(1);
        ifc.clk_kb = 1'b1;
        waitCycles(20);
        check("glitch_busy", {31'd0, ifc.oBusy}, 32'd0);
        ifc.data_kb = 1'b1;
        waitCycles(5);
        expectNone("glitch", 0);

        // Reset mid-frame
        snap();
        sendBits(frame(8'h75, 1'b0, 1'b1), 6);
        check("midFrame_busy", {31'd0, ifc.oBusy}, 32'd1);
        ifc.data_kb = 1'b1;
        Reset = 1'b1;
        waitCycles(3);
        checkAllZero("midReset");
        Reset = 1'b0;
        waitCycles(300);
        expectNone("midReset_quiet", 0);
        check("midReset_busyAfter", {31'd0, ifc.oBusy}, 32'd0);
        snap();
        sendByte(8'h1C, 1'b0, 1'b1);
        expectCode("afterReset", 8'h1C, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
